// File: rtl/idp_stepper.sv
// idp_stepper: single-step integer datapath core.
// A raw push button is synchronised, debounced and edge-detected; each
// accepted press runs one register-file -> ALU -> register-file operation
// through a SAMPLE / EXEC / WRITE sequence.
module idp_stepper #(
   parameter int WIDTH     = 16,
   parameter int NREG      = 8,
   parameter int DB_CYCLES = 250000,
   localparam int ADR_W    = $clog2(NREG)
) (
   input  logic             clk,
   input  logic             reset,
   input  logic             step,
   input  logic             w_en,
   input  logic [ADR_W-1:0] w_adr,
   input  logic [ADR_W-1:0] r_adr,
   input  logic [ADR_W-1:0] s_adr,
   input  logic [WIDTH-1:0] ds,
   input  logic             s_sel,
   input  logic [3:0]       alu_op,
   output logic             busy,
   output logic             done,
   output logic             c,
   output logic             n,
   output logic             z,
   output logic [WIDTH-1:0] reg_out,
   output logic [WIDTH-1:0] alu_out
);

   localparam int CNT_W = $clog2(DB_CYCLES + 1);
   localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(DB_CYCLES - 1);

   typedef enum logic [1:0] {
      IDLE,
      SAMPLE,
      EXEC,
      WRITE
   } state_t;

   state_t state;
   state_t state_next;

   logic             step_meta;
   logic             step_sync;
   logic             db_level;
   logic             db_prev;
   logic [CNT_W-1:0] db_cnt;
   logic             go;

   logic [WIDTH-1:0] regs [NREG];

   logic [WIDTH-1:0] r_lat;
   logic [WIDTH-1:0] s_lat;
   logic [3:0]       op_lat;
   logic [ADR_W-1:0] w_adr_lat;
   logic             w_en_lat;

   logic [WIDTH:0]   wide;
   logic [WIDTH-1:0] alu_res;
   logic             alu_c;

   // Two-flop synchroniser bringing the asynchronous button into clk
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         step_meta <= 1'b0;
         step_sync <= 1'b0;
      end else begin
         step_meta <= step;
         step_sync <= step_meta;
      end
   end

   // Debouncer: accept a new level only after DB_CYCLES consecutive disagreeing samples
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         db_level <= 1'b0;
         db_cnt   <= '0;
      end else if (step_sync != db_level) begin
         if (db_cnt == CNT_LAST) begin
            db_level <= step_sync;
            db_cnt   <= '0;
         end else begin
            db_cnt <= db_cnt + CNT_W'(1);
         end
      end else begin
         db_cnt <= '0;
      end
   end

   // Delayed debounced level for rising-edge detection
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         db_prev <= 1'b0;
      end else begin
         db_prev <= db_level;
      end
   end

   assign go = db_level & ~db_prev;

   // FSM state register
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state <= IDLE;
      end else begin
         state <= state_next;
      end
   end

   // FSM next state; a go seen outside IDLE is simply dropped
   always_comb begin
      state_next = state;
      case (state)
         IDLE:    if (go) state_next = SAMPLE;
         SAMPLE:  state_next = EXEC;
         EXEC:    state_next = WRITE;
         WRITE:   state_next = IDLE;
         default: state_next = IDLE;
      endcase
   end

   assign busy = (state != IDLE);

   // Operand and control capture so later input changes cannot disturb the operation
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         r_lat     <= '0;
         s_lat     <= '0;
         op_lat    <= '0;
         w_adr_lat <= '0;
         w_en_lat  <= 1'b0;
      end else if (state == SAMPLE) begin
         r_lat     <= regs[r_adr];
         s_lat     <= s_sel ? ds : regs[s_adr];
         op_lat    <= alu_op;
         w_adr_lat <= w_adr;
         w_en_lat  <= w_en;
      end
   end

   // ALU: arithmetic at WIDTH+1 bits so the top bit yields carry or borrow
   always_comb begin
      wide    = '0;
      alu_res = '0;
      alu_c   = 1'b0;
      case (op_lat)
         4'h0: alu_res = r_lat;
         4'h1: alu_res = s_lat;
         4'h2: begin
            wide    = {1'b0, r_lat} + {1'b0, s_lat};
            alu_res = wide[WIDTH-1:0];
            alu_c   = wide[WIDTH];
         end
         4'h3: begin
            wide    = {1'b0, r_lat} - {1'b0, s_lat};
            alu_res = wide[WIDTH-1:0];
            alu_c   = wide[WIDTH];
         end
         4'h4: begin
            wide    = {1'b0, s_lat} - {1'b0, r_lat};
            alu_res = wide[WIDTH-1:0];
            alu_c   = wide[WIDTH];
         end
         4'h5: alu_res = r_lat & s_lat;
         4'h6: alu_res = r_lat | s_lat;
         4'h7: alu_res = r_lat ^ s_lat;
         4'h8: alu_res = ~s_lat;
         4'h9: begin
            wide    = {1'b0, s_lat} + (WIDTH+1)'(1);
            alu_res = wide[WIDTH-1:0];
            alu_c   = wide[WIDTH];
         end
         4'hA: begin
            wide    = {1'b0, s_lat} - (WIDTH+1)'(1);
            alu_res = wide[WIDTH-1:0];
            alu_c   = wide[WIDTH];
         end
         4'hB: begin
            alu_res = {s_lat[WIDTH-2:0], 1'b0};
            alu_c   = s_lat[WIDTH-1];
         end
         4'hC: begin
            alu_res = {1'b0, s_lat[WIDTH-1:1]};
            alu_c   = s_lat[0];
         end
         4'hD: begin
            alu_res = {s_lat[WIDTH-1], s_lat[WIDTH-1:1]};
            alu_c   = s_lat[0];
         end
         4'hE: alu_res = '0;
         4'hF: alu_res = '1;
         default: alu_res = '0;
      endcase
   end

   // Result and flags are loaded only in EXEC
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         alu_out <= '0;
         c       <= 1'b0;
         n       <= 1'b0;
         z       <= 1'b0;
      end else if (state == EXEC) begin
         alu_out <= alu_res;
         c       <= alu_c;
         n       <= alu_res[WIDTH-1];
         z       <= (alu_res == '0);
      end
   end

   // Register file with write-back in WRITE when enabled
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int i = 0; i < NREG; i++) begin
            regs[i] <= '0;
         end
      end else if ((state == WRITE) && w_en_lat) begin
         regs[w_adr_lat] <= alu_out;
      end
   end

   // Completion pulse in the cycle after WRITE
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         done <= 1'b0;
      end else begin
         done <= (state == WRITE);
      end
   end

   assign reg_out = regs[r_adr];

endmodule

// File: tb/tb_idp_stepper.sv
// Self-checking bench for idp_stepper: table-driven vectors on a 16-bit
// instance plus hand-written sequences for debounce, busy and reset cases;
// an 8-bit fast-debounce instance covers narrow-width shifts and go-while-busy.
module tb_idp_stepper;

   typedef struct {
      logic [15:0] ds;
      logic        s_sel;
      logic [3:0]  op;
      logic [2:0]  r_adr;
      logic [2:0]  s_adr;
      logic [2:0]  w_adr;
      logic        w_en;
      logic [15:0] exp_alu;
      logic        exp_c;
      logic        exp_n;
      logic        exp_z;
      logic [2:0]  chk_adr;
      logic [15:0] exp_reg;
   } vec_t;

   localparam int NV = 20;

   logic        clk = 1'b0;
   logic        reset;
   logic        step;
   logic        w_en;
   logic [2:0]  w_adr, r_adr, s_adr;
   logic [15:0] ds;
   logic        s_sel;
   logic [3:0]  alu_op;
   logic        busy, done, c, n, z;
   logic [15:0] reg_out, alu_out;

   logic        sm_step;
   logic        sm_w_en;
   logic [1:0]  sm_w_adr, sm_r_adr, sm_s_adr;
   logic [7:0]  sm_ds;
   logic        sm_s_sel;
   logic [3:0]  sm_alu_op;
   logic        sm_busy, sm_done, sm_c, sm_n, sm_z;
   logic [7:0]  sm_reg_out, sm_alu_out;

   int   checks = 0;
   int   errors = 0;
   vec_t vecs [NV];

   always #5 clk = ~clk;

   idp_stepper #(.WIDTH(16), .NREG(8), .DB_CYCLES(4)) dut (
      .clk(clk), .reset(reset), .step(step), .w_en(w_en),
      .w_adr(w_adr), .r_adr(r_adr), .s_adr(s_adr), .ds(ds),
      .s_sel(s_sel), .alu_op(alu_op), .busy(busy), .done(done),
      .c(c), .n(n), .z(z), .reg_out(reg_out), .alu_out(alu_out)
   );

   idp_stepper #(.WIDTH(8), .NREG(4), .DB_CYCLES(1)) dut_small (
      .clk(clk), .reset(reset), .step(sm_step), .w_en(sm_w_en),
      .w_adr(sm_w_adr), .r_adr(sm_r_adr), .s_adr(sm_s_adr), .ds(sm_ds),
      .s_sel(sm_s_sel), .alu_op(sm_alu_op), .busy(sm_busy), .done(sm_done),
      .c(sm_c), .n(sm_n), .z(sm_z), .reg_out(sm_reg_out), .alu_out(sm_alu_out)
   );

   task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("[TB] FAIL %s actual %h expected %h", name, act, exp);
      end
   endtask

   task automatic applyStimulus(input vec_t v);
      ds     = v.ds;
      s_sel  = v.s_sel;
      alu_op = v.op;
      r_adr  = v.r_adr;
      s_adr  = v.s_adr;
      w_adr  = v.w_adr;
      w_en   = v.w_en;
   endtask

   // Press the main button until busy appears (returns in SAMPLE), then release
   task automatic startOp(input string name, output logic got);
      got  = 1'b0;
      step = 1'b1;
      for (int k = 0; k < 40 && !got; k++) begin
         @(negedge clk);
         if (busy) got = 1'b1;
      end
      step = 1'b0;
      checkOutput({name, " start"}, 32'(got), 32'd1);
   endtask

   task automatic smallOp(input string name, input logic [7:0] d, input logic [3:0] op,
                          input logic [7:0] exp_alu, input logic exp_c, input logic exp_n);
      logic got;
      got       = 1'b0;
      sm_ds     = d;
      sm_s_sel  = 1'b1;
      sm_alu_op = op;
      sm_w_en   = 1'b0;
      sm_step   = 1'b1;
      for (int k = 0; k < 40 && !got; k++) begin
         @(negedge clk);
         if (sm_busy) got = 1'b1;
      end
      sm_step = 1'b0;
      checkOutput({name, " start"}, 32'(got), 32'd1);
      repeat (2) @(negedge clk);
      checkOutput({name, " alu"}, 32'(sm_alu_out), 32'(exp_alu));
      checkOutput({name, " c"}, 32'(sm_c), 32'(exp_c));
      checkOutput({name, " n"}, 32'(sm_n), 32'(exp_n));
      checkOutput({name, " z"}, 32'(sm_z), 32'd0);
      repeat (6) @(negedge clk);
   endtask

   initial begin
      logic got;
      int   busy_hits;
      int   done_hits;

      //            ds       sel   op    r     s     w     en    alu      c     n     z     chk   reg
      vecs[0]  = '{16'hAA55, 1'b1, 4'h1, 3'd0, 3'd0, 3'd3, 1'b1, 16'hAA55, 1'b0, 1'b1, 1'b0, 3'd3, 16'hAA55};
      vecs[1]  = '{16'hFFFF, 1'b1, 4'h1, 3'd0, 3'd0, 3'd1, 1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b0, 3'd1, 16'hFFFF};
      vecs[2]  = '{16'h0001, 1'b1, 4'h1, 3'd0, 3'd0, 3'd2, 1'b1, 16'h0001, 1'b0, 1'b0, 1'b0, 3'd2, 16'h0001};
      vecs[3]  = '{16'h0000, 1'b0, 4'h2, 3'd1, 3'd2, 3'd0, 1'b0, 16'h0000, 1'b1, 1'b0, 1'b1, 3'd0, 16'h0000};
      vecs[4]  = '{16'h0000, 1'b0, 4'h3, 3'd2, 3'd1, 3'd2, 1'b0, 16'h0002, 1'b1, 1'b0, 1'b0, 3'd2, 16'h0001};
      vecs[5]  = '{16'h0005, 1'b1, 4'h4, 3'd2, 3'd0, 3'd4, 1'b1, 16'h0004, 1'b0, 1'b0, 1'b0, 3'd4, 16'h0004};
      vecs[6]  = '{16'h0FF0, 1'b1, 4'h5, 3'd3, 3'd0, 3'd5, 1'b1, 16'h0A50, 1'b0, 1'b0, 1'b0, 3'd5, 16'h0A50};
      vecs[7]  = '{16'h5500, 1'b1, 4'h6, 3'd3, 3'd0, 3'd5, 1'b0, 16'hFF55, 1'b0, 1'b1, 1'b0, 3'd5, 16'h0A50};
      vecs[8]  = '{16'hAA55, 1'b1, 4'h7, 3'd3, 3'd0, 3'd3, 1'b0, 16'h0000, 1'b0, 1'b0, 1'b1, 3'd3, 16'hAA55};
      vecs[9]  = '{16'h00FF, 1'b1, 4'h8, 3'd0, 3'd0, 3'd0, 1'b0, 16'hFF00, 1'b0, 1'b1, 1'b0, 3'd0, 16'h0000};
      vecs[10] = '{16'h0000, 1'b1, 4'hA, 3'd0, 3'd0, 3'd0, 1'b0, 16'hFFFF, 1'b1, 1'b1, 1'b0, 3'd0, 16'h0000};
      vecs[11] = '{16'h0000, 1'b0, 4'h9, 3'd0, 3'd1, 3'd1, 1'b1, 16'h0000, 1'b1, 1'b0, 1'b1, 3'd1, 16'h0000};
      vecs[12] = '{16'h0003, 1'b1, 4'hC, 3'd0, 3'd0, 3'd1, 1'b0, 16'h0001, 1'b1, 1'b0, 1'b0, 3'd1, 16'h0000};
      vecs[13] = '{16'h8002, 1'b1, 4'hD, 3'd0, 3'd0, 3'd4, 1'b0, 16'hC001, 1'b0, 1'b1, 1'b0, 3'd4, 16'h0004};
      vecs[14] = '{16'h8001, 1'b1, 4'hB, 3'd0, 3'd0, 3'd6, 1'b1, 16'h0002, 1'b1, 1'b0, 1'b0, 3'd6, 16'h0002};
      vecs[15] = '{16'hFFFF, 1'b1, 4'hE, 3'd0, 3'd0, 3'd6, 1'b1, 16'h0000, 1'b0, 1'b0, 1'b1, 3'd6, 16'h0000};
      vecs[16] = '{16'h0000, 1'b1, 4'hF, 3'd0, 3'd0, 3'd7, 1'b1, 16'hFFFF, 1'b0, 1'b1, 1'b0, 3'd7, 16'hFFFF};
      vecs[17] = '{16'h0000, 1'b1, 4'h0, 3'd4, 3'd0, 3'd4, 1'b0, 16'h0004, 1'b0, 1'b0, 1'b0, 3'd4, 16'h0004};
      vecs[18] = '{16'h0001, 1'b1, 4'h2, 3'd3, 3'd0, 3'd3, 1'b0, 16'hAA56, 1'b0, 1'b1, 1'b0, 3'd3, 16'hAA55};
      vecs[19] = '{16'h7FFF, 1'b1, 4'h9, 3'd0, 3'd0, 3'd7, 1'b0, 16'h8000, 1'b0, 1'b1, 1'b0, 3'd7, 16'hFFFF};

      reset = 1'b0;
      step = 1'b0; w_en = 1'b0; w_adr = '0; r_adr = '0; s_adr = '0;
      ds = '0; s_sel = 1'b0; alu_op = '0;
      sm_step = 1'b0; sm_w_en = 1'b0; sm_w_adr = '0; sm_r_adr = '0; sm_s_adr = '0;
      sm_ds = '0; sm_s_sel = 1'b0; sm_alu_op = '0;
      repeat (3) @(negedge clk);

      // Reset state
      checkOutput("rst busy", 32'(busy), 32'd0);
      checkOutput("rst done", 32'(done), 32'd0);
      checkOutput("rst alu", 32'(alu_out), 32'd0);
      checkOutput("rst flags", 32'({c, n, z}), 32'd0);
      checkOutput("rst reg", 32'(reg_out), 32'd0);
      checkOutput("rst sm busy", 32'(sm_busy), 32'd0);
      reset = 1'b1;
      repeat (2) @(negedge clk);

      // Table-driven operations on the 16-bit instance
      for (int i = 0; i < NV; i++) begin
         applyStimulus(vecs[i]);
         startOp($sformatf("v%0d", i), got);
         if (got) begin
            repeat (2) @(negedge clk);
            checkOutput($sformatf("v%0d alu", i), 32'(alu_out), 32'(vecs[i].exp_alu));
            checkOutput($sformatf("v%0d c", i), 32'(c), 32'(vecs[i].exp_c));
            checkOutput($sformatf("v%0d n", i), 32'(n), 32'(vecs[i].exp_n));
            checkOutput($sformatf("v%0d z", i), 32'(z), 32'(vecs[i].exp_z));
            checkOutput($sformatf("v%0d write busy", i), 32'({busy, done}), 32'b10);
            @(negedge clk);
            checkOutput($sformatf("v%0d done", i), 32'({busy, done}), 32'b01);
            r_adr = vecs[i].chk_adr;
            #1;
            checkOutput($sformatf("v%0d reg", i), 32'(reg_out), 32'(vecs[i].exp_reg));
         end
         repeat (8) @(negedge clk);
      end

      // Same read/write address, inputs changed after SAMPLE
      ds = 16'h1233; s_sel = 1'b1; alu_op = 4'h9; r_adr = 3'd7; w_adr = 3'd7; w_en = 1'b1;
      startOp("rw", got);
      if (got) begin
         @(negedge clk);
         ds = 16'h0000;
         alu_op = 4'hE;
         @(negedge clk);
         checkOutput("rw alu", 32'(alu_out), 32'h1234);
         checkOutput("rw old reg", 32'(reg_out), 32'hFFFF);
         @(negedge clk);
         checkOutput("rw done", 32'(done), 32'd1);
         checkOutput("rw new reg", 32'(reg_out), 32'h1234);
      end
      repeat (8) @(negedge clk);

      // Bounce: 3-cycle high pulses must never start an operation
      ds = 16'h0000; s_sel = 1'b1; alu_op = 4'h0; r_adr = 3'd4; w_en = 1'b0;
      busy_hits = 0;
      for (int p = 0; p < 5; p++) begin
         step = 1'b1;
         repeat (3) begin @(negedge clk); if (busy) busy_hits++; end
         step = 1'b0;
         repeat (2) begin @(negedge clk); if (busy) busy_hits++; end
      end
      repeat (10) begin @(negedge clk); if (busy) busy_hits++; end
      checkOutput("bounce busy", 32'(busy_hits), 32'd0);

      // Long hold yields exactly one operation
      done_hits = 0;
      step = 1'b1;
      repeat (20) begin @(negedge clk); if (done) done_hits++; end
      step = 1'b0;
      repeat (20) begin @(negedge clk); if (done) done_hits++; end
      checkOutput("hold ops", 32'(done_hits), 32'd1);
      checkOutput("hold alu", 32'(alu_out), 32'h0004);

      // Small instance: second go lands in EXEC and must be dropped
      sm_s_sel = 1'b0; sm_s_adr = 2'd1; sm_alu_op = 4'h9; sm_w_adr = 2'd1; sm_w_en = 1'b1; sm_r_adr = 2'd1;
      sm_step = 1'b1; @(negedge clk);
      sm_step = 1'b0; @(negedge clk);
      sm_step = 1'b1; @(negedge clk);
      sm_step = 1'b0;
      busy_hits = 0;
      done_hits = 0;
      repeat (15) begin
         @(negedge clk);
         if (sm_busy) busy_hits++;
         if (sm_done) done_hits++;
      end
      checkOutput("busy go ops", 32'(done_hits), 32'd1);
      checkOutput("busy go cycles", 32'(busy_hits), 32'd3);
      checkOutput("busy go reg", 32'(sm_reg_out), 32'h01);

      // Narrow-width shifts
      smallOp("w8 asr", 8'h81, 4'hD, 8'hC0, 1'b1, 1'b1);
      smallOp("w8 shl", 8'h81, 4'hB, 8'h02, 1'b1, 1'b0);

      // Reset in EXEC aborts with no write-back
      ds = 16'h0000; s_sel = 1'b1; alu_op = 4'hF; r_adr = 3'd5; w_adr = 3'd5; w_en = 1'b1;
      startOp("abort", got);
      if (got) begin
         @(negedge clk);
         reset = 1'b0;
         #1;
         checkOutput("abort busy", 32'(busy), 32'd0);
         checkOutput("abort done", 32'(done), 32'd0);
         checkOutput("abort alu", 32'(alu_out), 32'd0);
         checkOutput("abort flags", 32'({c, n, z}), 32'd0);
         checkOutput("abort reg", 32'(reg_out), 32'd0);
         repeat (3) @(negedge clk);
         reset = 1'b1;
         repeat (10) @(negedge clk);
         checkOutput("abort idle", 32'({busy, done}), 32'd0);
         checkOutput("abort no write", 32'(reg_out), 32'd0);
      end

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

   // Global watchdog so the run always ends
   initial begin
      #500000;
      $display("[TB] FAIL watchdog actual timeout expected finish");
      $fatal(1, "[TB] watchdog expired");
   end

endmodule

// File: doc/idp_stepper.md
# idp_stepper

Parametrised single-step integer datapath core: a WIDTH-bit, NREG-entry register file feeding a 16-operation ALU with C/N/Z flags. Execution is driven by a raw push-button input that the block synchronises, debounces and edge-detects internally, then sequences through a three-state read/execute/write FSM. It sits between the board-level switch/button inputs and the seven-segment display controller. It is the next-generation replacement for the fixed 16-bit, 8-register datapath and its external debouncer.

## Interface
- WIDTH, 16, datapath and register width (≥4)
- NREG, 8, register count (power of two ≥2); ADR_W = $clog2(NREG)
- DB_CYCLES, 250000, stable cycles required to accept a button level change
- clk  in  1  system clock; one clock domain
- reset  in  1  asynchronous, active-low reset
- step  in  1  raw, bouncy step button, asynchronous to clk
- w_en  in  1  write-back enable for the operation
- w_adr, r_adr, s_adr  in  ADR_W each  write, R-operand and S-operand addresses
- ds  in  WIDTH  direct-source operand
- s_sel  in  1  1: S = ds; 0: S = reg[s_adr]
- alu_op  in  4  ALU operation code
- busy  out  1  high while FSM not IDLE
- done  out  1  one-cycle pulse on operation completion
- c, n, z  out  1 each  carry/borrow, negative, zero flags (registered)
- reg_out  out  WIDTH  live combinational read of reg[r_adr]
- alu_out  out  WIDTH  registered ALU result of last operation

## Operation
- Reset (reset=0): all registers, alu_out, c, n, z, busy, done = 0; FSM = IDLE; debouncer level = 0, counter cleared. Takes effect immediately and aborts any in-flight operation; no write-back occurs.
- Input path: step → 2-FF synchroniser → debouncer. The debounced level toggles only after the synchronised value has differed from it for DB_CYCLES consecutive cycles. Any mismatch gap resets the counter. A rising edge of the debounced level produces a one-cycle go pulse.
- FSM:
  - IDLE: on go → SAMPLE.
  - SAMPLE: latch R = reg[r_adr], S per s_sel, alu_op, w_adr, w_en → EXEC.
  - EXEC: compute result, load alu_out and c/n/z → WRITE.
  - WRITE: if latched w_en, reg[w_adr] = alu_out; assert done next cycle → IDLE.
- go pulses arriving while busy are discarded, not queued. Holding step high yields exactly one operation.
- Inputs changing after SAMPLE do not affect the operation.
- ALU ops:
  - 0 R; 1 S; 2 R+S; 3 R−S; 4 S−R
  - 5 R&S; 6 R|S; 7 R^S; 8 ~S
  - 9 S+1; A S−1
  - B S<<1; C S>>1 logical; D S>>>1 arithmetic
  - E zero; F all ones
- Width rule: arithmetic is computed at WIDTH+1 bits, and the result is truncated to WIDTH.
- c flag:
  - add/inc: carry out.
  - sub/dec: borrow, i.e. c=1 when the minuend is less than the subtrahend unsigned; S−1 with S=0 gives c=1.
  - B: c = S[WIDTH−1]. C, D: c = S[0].
  - All other ops: c=0.
- n = result[WIDTH−1]; z = (result == 0). Flags change only in EXEC.

## Timing
- Button press to go pulse: 2 sync cycles + DB_CYCLES. The debounced level rises on the DB_CYCLES-th consecutive high sample; go is high the following cycle.
- Cycle k = go high (FSM IDLE). Cycle k+1: SAMPLE, busy=1. k+2: EXEC. k+3: WRITE, alu_out/flags valid. k+4: IDLE, done=1, busy=0, written value visible on reg_out.
- Back-to-back operations need a release (debounced low) and a new press.
- w_adr == r_adr: reg_out shows the old value through WRITE and the new value from k+4.
- w_en=0: alu_out and flags update; register file unchanged.

## Test plan
- Reset then ds=16'hAA55, s_sel=1, alu_op=1, w_adr=3, w_en=1, one press (DB_CYCLES=4) → alu_out=AA55, n=1, z=0, c=0; done pulse; r_adr=3 gives reg_out=AA55.
- reg1=FFFF, reg2=0001, op 2, R=1, S=2 → alu_out=0000, c=1, z=1, n=0. Then op 3 with R=2, S=1 → 0002, c=1 (borrow).
- Bounce: step toggles with high pulses of 3 cycles (DB_CYCLES=4) → no go, busy stays 0. Hold 20 cycles → exactly one operation.
- Second press during busy (forced go) → ignored; register file written once.
- Assert reset at EXEC cycle → FSM IDLE, all outputs 0, target register still 0.
- WIDTH=8, NREG=4: S=8'h81, op D → alu_out=C0, c=1, n=1. Op B → 02, c=1.
